cdb_arbiter: RTL and testbench

Common-data-bus scheduler that shares the single result-broadcast path into the reorder buffer and reservation stations among three producers: ALU (value plus branch target), load/store buffer loads (value), and store-address-ready notifications. Each producer gets a small FIFO. Round-robin arbitration drains at most one entry per cycle onto a registered bus. The block sits between the execution units and the ROB/RS/LSB writeback inputs. A ROB commit-jump flush empties it.

---
 rtl/cdb_arbiter.sv | 149 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: three per-producer FIFOs (ALU, load, store-ready)
// drained round-robin, one entry per cycle, onto a registered broadcast bus.
module cdb_arbiter #(
    parameter int ROB_LOG  = 4,
    parameter int FIFO_LOG = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic               alu_valid,
    input  logic [ROB_LOG-1:0] alu_rob_id,
    input  logic [31:0]        alu_value,
    input  logic [31:0]        alu_topc,
    output logic               alu_full,
    input  logic               lsb_valid,
    input  logic [ROB_LOG-1:0] lsb_rob_id,
    input  logic [31:0]        lsb_value,
    output logic               lsb_full,
    input  logic               st_valid,
    input  logic [ROB_LOG-1:0] st_rob_id,
    output logic               st_full,
    output logic               cdb_valid,
    output logic [1:0]         cdb_src,
    output logic [ROB_LOG-1:0] cdb_rob_id,
    output logic [31:0]        cdb_value,
    output logic [31:0]        cdb_topc
);
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam logic [FIFO_LOG:0] CNT_DEPTH = (FIFO_LOG+1)'(DEPTH);
    localparam logic [FIFO_LOG:0] CNT_AFULL = (FIFO_LOG+1)'(DEPTH - 1);

    logic [ROB_LOG-1:0] w_in_rob  [3];
    logic [31:0]        w_in_val  [3];
    logic [31:0]        w_in_pc   [3];
    logic [ROB_LOG-1:0] w_head_rob[3];
    logic [31:0]        w_head_val[3];
    logic [31:0]        w_head_pc [3];
    logic [FIFO_LOG:0]  w_cnt     [3];
    logic [2:0]         w_push, w_acc, w_pop, w_full;
    logic [1:0]         w_ord     [3];
    logic [1:0]         w_grant;
    logic               w_any;

    logic [1:0]         r_last;
    logic               r_cdb_valid;
    logic [1:0]         r_cdb_src;
    logic [ROB_LOG-1:0] r_cdb_rob;
    logic [31:0]        r_cdb_val;
    logic [31:0]        r_cdb_pc;

    assign w_push      = {st_valid, lsb_valid, alu_valid};
    assign w_in_rob[0] = alu_rob_id;
    assign w_in_rob[1] = lsb_rob_id;
    assign w_in_rob[2] = st_rob_id;
    assign w_in_val[0] = alu_value;
    assign w_in_val[1] = lsb_value;
    assign w_in_val[2] = '0;
    assign w_in_pc[0]  = alu_topc;
    assign w_in_pc[1]  = '1;
    assign w_in_pc[2]  = '1;

    for (genvar s = 0; s < 3; s++) begin : g_fifo
        logic [FIFO_LOG-1:0] r_wp, r_rp;
        logic [FIFO_LOG:0]   r_cnt;
        logic [ROB_LOG-1:0]  r_mem_rob[DEPTH];
        logic [31:0]         r_mem_val[DEPTH];
        logic [31:0]         r_mem_pc [DEPTH];

        // a push into a completely full FIFO is dropped, judged on the pre-edge count
        assign w_acc[s]      = w_push[s] && (r_cnt != CNT_DEPTH);
        assign w_full[s]     = r_cnt >= CNT_AFULL;
        assign w_cnt[s]      = r_cnt;
        assign w_head_rob[s] = r_mem_rob[r_rp];
        assign w_head_val[s] = r_mem_val[r_rp];
        assign w_head_pc[s]  = r_mem_pc[r_rp];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else if (rdy) begin
                if (w_acc[s]) r_wp <= r_wp + 1'b1;
                if (w_pop[s]) r_rp <= r_rp + 1'b1;
                if (w_acc[s] && !w_pop[s])
                    r_cnt <= r_cnt + 1'b1;
                else if (!w_acc[s] && w_pop[s])
                    r_cnt <= r_cnt - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst && !flush && rdy && w_acc[s]) begin
                r_mem_rob[r_wp] <= w_in_rob[s];
                r_mem_val[r_wp] <= w_in_val[s];
                r_mem_pc[r_wp]  <= w_in_pc[s];
            end
        end
    end

    // search order begins just after the last winner; later checks override earlier ones
    always_comb begin
        w_ord[0] = 2'd0;
        w_ord[1] = 2'd1;
        w_ord[2] = 2'd2;
        if (r_last == 2'd0) begin
            w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0;
        end else if (r_last == 2'd1) begin
            w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1;
        end
        w_any   = 1'b0;
        w_grant = '0;
        if (w_cnt[w_ord[2]] != '0) begin w_any = 1'b1; w_grant = w_ord[2]; end
        if (w_cnt[w_ord[1]] != '0) begin w_any = 1'b1; w_grant = w_ord[1]; end
        if (w_cnt[w_ord[0]] != '0) begin w_any = 1'b1; w_grant = w_ord[0]; end
    end

    assign w_pop = w_any ? (3'b001 << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cdb_valid <= 1'b0;
            r_cdb_src   <= '0;
            r_cdb_rob   <= '0;
            r_cdb_val   <= '0;
            r_cdb_pc    <= '1;
            r_last      <= 2'd2;
        end else if (rdy) begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_src <= w_grant;
                r_cdb_rob <= w_head_rob[w_grant];
                r_cdb_val <= w_head_val[w_grant];
                r_cdb_pc  <= w_head_pc[w_grant];
                r_last    <= w_grant;
            end
        end
    end

    assign alu_full   = w_full[0];
    assign lsb_full   = w_full[1];
    assign st_full    = w_full[2];
    assign cdb_valid  = r_cdb_valid;
    assign cdb_src    = r_cdb_src;
    assign cdb_rob_id = r_cdb_rob;
    assign cdb_value  = r_cdb_val;
    assign cdb_topc   = r_cdb_pc;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the round-robin broadcast behaviour.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        alu_valid, lsb_valid, st_valid;
    logic [3:0]  alu_rob_id, lsb_rob_id, st_rob_id;
    logic [31:0] alu_value, alu_topc, lsb_value;
    logic        alu_full, lsb_full, st_full;
    logic        cdb_valid;
    logic [1:0]  cdb_src;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value, cdb_topc;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.ROB_LOG(4), .FIFO_LOG(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .alu_topc(alu_topc), .alu_full(alu_full),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .lsb_full(lsb_full),
        .st_valid(st_valid), .st_rob_id(st_rob_id), .st_full(st_full),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .cdb_topc(cdb_topc)
    );

    always #5 clk = ~clk;

    // reference model: one queue per source, plain round-robin over queue sizes
    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] val;
        logic [31:0] pc;
    } ent_t;

    ent_t        q_alu[$], q_lsb[$], q_st[$];
    logic        m_valid;
    logic [1:0]  m_src;
    logic [3:0]  m_rob;
    logic [31:0] m_val, m_pc;
    logic [2:0]  m_full;
    int          m_last;

    task automatic model_edge();
        int   sz[3];
        int   g;
        ent_t e;
        if (rst || flush) begin
            q_alu.delete(); q_lsb.delete(); q_st.delete();
            m_valid = 1'b0; m_src = 2'd0; m_rob = 4'd0; m_val = 32'd0;
            m_pc = 32'hFFFF_FFFF; m_last = 2;
        end else if (rdy) begin
            sz[0] = q_alu.size(); sz[1] = q_lsb.size(); sz[2] = q_st.size();
            g = -1;
            for (int k = 0; k < 3; k++) begin
                int s = (m_last + 1 + k) % 3;
                if (g < 0 && sz[s] > 0) g = s;
            end
            if (g >= 0) begin
                case (g)
                    0:       e = q_alu.pop_front();
                    1:       e = q_lsb.pop_front();
                    default: e = q_st.pop_front();
                endcase
                m_valid = 1'b1; m_src = 2'(g); m_rob = e.rob; m_val = e.val; m_pc = e.pc;
                m_last = g;
            end else begin
                m_valid = 1'b0;
            end
            if (alu_valid && sz[0] < 4) q_alu.push_back({alu_rob_id, alu_value, alu_topc});
            if (lsb_valid && sz[1] < 4) q_lsb.push_back({lsb_rob_id, lsb_value, 32'hFFFF_FFFF});
            if (st_valid  && sz[2] < 4) q_st.push_back({st_rob_id, 32'd0, 32'hFFFF_FFFF});
        end
        m_full = {q_st.size() >= 3, q_lsb.size() >= 3, q_alu.size() >= 3};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; lsb_valid = 1'b0; st_valid = 1'b0;
        alu_rob_id = '0; lsb_rob_id = '0; st_rob_id = '0;
        alu_value = '0; alu_topc = '0; lsb_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc} !==
            {1'b0, 2'd0, 4'd0, 32'd0, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL reset_bus: got %b/%0d/%0d/%h/%h required 0/0/0/00000000/ffffffff",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc);
        end
        n_checks++;
        if ({alu_full, lsb_full, st_full} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_full: got %b required 000", {alu_full, lsb_full, st_full});
        end
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h1234; alu_topc = 32'h100;
        tick();
        idle_inputs();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_cycle1_valid: got %b required 0", cdb_valid);
        end
        tick();
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc} !==
            {1'b1, 2'd0, 4'd5, 32'h1234, 32'h100}) begin
            n_fail++;
            $display("FAIL single_bcast: got %b/%0d/%0d/%h/%h required 1/0/5/00001234/00000100",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_cycle3_valid: got %b required 0", cdb_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [70:0] exp_v[3];
        do_reset();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'h11; alu_topc = 32'h200;
        lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'hAA;
        st_valid  = 1'b1; st_rob_id  = 4'd3;
        tick();
        idle_inputs();
        exp_v[0] = {1'b1, 2'd0, 4'd1, 32'h11, 32'h200};
        exp_v[1] = {1'b1, 2'd1, 4'd2, 32'hAA, 32'hFFFF_FFFF};
        exp_v[2] = {1'b1, 2'd2, 4'd3, 32'h0,  32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL simul_grant%0d: got %h required %h", i,
                         {cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc}, exp_v[i]);
            end
        end
    endtask

    task automatic test_contention();
        int got_src[$];
        int got_rob[$];
        do_reset();
        for (int c = 0; c < 14; c++) begin
            alu_valid = (c < 4); alu_rob_id = 4'(c);     alu_value = 32'h100 + 32'(c); alu_topc = 32'h40 * 32'(c);
            lsb_valid = (c < 4); lsb_rob_id = 4'(8 + c); lsb_value = 32'h200 + 32'(c);
            tick();
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc, st_full, lsb_full, alu_full} !==
                {m_valid, m_src, m_rob, m_val, m_pc, m_full}) begin
                n_fail++;
                $display("FAIL contention_bus cycle %0d: got %h required %h", c,
                         {cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc, st_full, lsb_full, alu_full},
                         {m_valid, m_src, m_rob, m_val, m_pc, m_full});
            end
            if (cdb_valid === 1'b1) begin
                got_src.push_back(int'(cdb_src));
                got_rob.push_back(int'(cdb_rob_id));
            end
        end
        idle_inputs();
        n_checks++;
        if (got_src.size() != 8) begin
            n_fail++; $display("FAIL contention_count: got %0d required 8", got_src.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_src[i] != i % 2 || got_rob[i] != (i % 2) * 8 + i / 2) begin
                    n_fail++;
                    $display("FAIL contention_order %0d: got src %0d rob %0d required src %0d rob %0d",
                             i, got_src[i], got_rob[i], i % 2, (i % 2) * 8 + i / 2);
                end
            end
        end
    endtask

    task automatic test_full();
        logic saw_full = 1'b0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            alu_valid = !m_full[0] && c < 8; alu_rob_id = 4'(c); alu_value = 32'(c); alu_topc = 32'(c * 4);
            lsb_valid = !m_full[1] && c < 8; lsb_rob_id = 4'(c); lsb_value = 32'(c + 50);
            st_valid  = !m_full[2] && c < 8; st_rob_id  = 4'(c);
            tick();
            if (alu_full === 1'b1) saw_full = 1'b1;
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc, st_full, lsb_full, alu_full} !==
                {m_valid, m_src, m_rob, m_val, m_pc, m_full}) begin
                n_fail++;
                $display("FAIL full_bus cycle %0d: got %h required %h", c,
                         {cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc, st_full, lsb_full, alu_full},
                         {m_valid, m_src, m_rob, m_val, m_pc, m_full});
            end
        end
        idle_inputs();
        n_checks++;
        if (saw_full !== 1'b1) begin
            n_fail++; $display("FAIL full_seen: got %b required 1", saw_full);
        end
    endtask

    task automatic test_wrap();
        ent_t exp_q[$];
        ent_t got_q[$];
        do_reset();
        for (int c = 0; c < 14; c++) begin
            alu_valid = (c < 10); alu_rob_id = 4'(c + 3);
            alu_value = 32'hC000 + 32'(c); alu_topc = 32'h1000 + 32'(c * 8);
            if (c < 10) exp_q.push_back({alu_rob_id, alu_value, alu_topc});
            tick();
            if (cdb_valid === 1'b1) got_q.push_back({cdb_rob_id, cdb_value, cdb_topc});
        end
        idle_inputs();
        n_checks++;
        if (got_q.size() != 10) begin
            n_fail++; $display("FAIL wrap_count: got %0d required 10", got_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL wrap_entry %0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        alu_valid = 1'b1; alu_rob_id = 4'd7; alu_value = 32'h77; alu_topc = 32'h300;
        lsb_valid = 1'b1; lsb_rob_id = 4'd8; lsb_value = 32'h88;
        st_valid  = 1'b1; st_rob_id  = 4'd9;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd7) begin
            n_fail++; $display("FAIL flush_first: got valid %b rob %0d required 1/7", cdb_valid, cdb_rob_id);
        end
        flush = 1'b1;
        alu_valid = 1'b1; alu_rob_id = 4'd10; alu_value = 32'hDEAD;
        tick();
        idle_inputs();
        n_checks++;
        if ({cdb_valid, cdb_topc, alu_full, lsb_full, st_full} !== {1'b0, 32'hFFFF_FFFF, 3'b000}) begin
            n_fail++;
            $display("FAIL flush_state: got valid %b topc %h full %b required 0/ffffffff/000",
                     cdb_valid, cdb_topc, {alu_full, lsb_full, st_full});
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (cdb_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_quiet cycle %0d: got valid %b required 0", c, cdb_valid);
            end
        end
    endtask

    task automatic test_rdy();
        do_reset();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'h501; alu_topc = 32'h600;
        lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'h502;
        st_valid  = 1'b1; st_rob_id  = 4'd3;
        tick();
        idle_inputs();
        tick();
        rdy = 1'b0;
        alu_valid = 1'b1; alu_rob_id = 4'd9; alu_value = 32'h999;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc} !==
                {1'b1, 2'd0, 4'd1, 32'h501, 32'h600}) begin
                n_fail++;
                $display("FAIL rdy_hold cycle %0d: got %b/%0d/%0d/%h/%h required 1/0/1/00000501/00000600",
                         c, cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 2'd1, 4'd2, 32'h502}) begin
            n_fail++;
            $display("FAIL rdy_resume_lsb: got %b/%0d/%0d/%h required 1/1/2/00000502",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        end
        tick();
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id} !== {1'b1, 2'd2, 4'd3}) begin
            n_fail++;
            $display("FAIL rdy_resume_st: got %b/%0d/%0d required 1/2/3", cdb_valid, cdb_src, cdb_rob_id);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL rdy_drained: got valid %b rob %0d required 0", cdb_valid, cdb_rob_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy   = ($urandom % 6) != 0;
            flush = ($urandom % 45) == 0;
            alu_valid = !m_full[0] && ($urandom % 2 == 0);
            lsb_valid = !m_full[1] && ($urandom % 3 == 0);
            st_valid  = !m_full[2] && ($urandom % 3 == 0);
            alu_rob_id = 4'($urandom); alu_value = $urandom; alu_topc = $urandom;
            lsb_rob_id = 4'($urandom); lsb_value = $urandom;
            st_rob_id  = 4'($urandom);
            tick();
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc, st_full, lsb_full, alu_full} !==
                {m_valid, m_src, m_rob, m_val, m_pc, m_full}) begin
                n_fail++;
                $display("FAIL random_bus cycle %0d: got %h required %h", c,
                         {cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_topc, st_full, lsb_full, alu_full},
                         {m_valid, m_src, m_rob, m_val, m_pc, m_full});
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_full = '0;
        m_last = 2;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_contention();
        test_full();
        test_wrap();
        test_flush();
        test_rdy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
